fetch_unit: RTL and testbench

- Instruction-fetch stage. Owns the PC and issues one instruction-memory read at a time.
- Produces the instruction / incremented_pc pair that the IF/ID pipeline register captures every clock.
- Handles three cases on the IF/ID write side: variable memory latency, load-use stalls from the hazard unit, and branch redirects/flushes from ID/EX.
- Delivers a NOP (32'h00000000, sll $0,$0,0) whenever no valid instruction is available.

---
 rtl/mips_pkg.sv | 15 +
 rtl/fetch_unit.sv | 126 ++++++++++++
 tb/tb_fetch_unit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch stage: NOP encoding, PC step
// and the fetch FSM state encoding.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000000;
  localparam int          PC_STEP   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one imem read in flight and
// feeds the IF/ID register, absorbing memory latency, stalls and branch flushes.
//
// imem handshake: a request is accepted in any cycle where imem_req and
// imem_ready are both high; exactly one response (imem_rvalid) follows one or
// more cycles later, and no new request is raised until that response is seen.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instruction,
  output logic [ADDR_W-1:0] incremented_pc
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);
  localparam logic [DATA_W-1:0] NOP  = DATA_W'(NOP_INSTR);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic              kill_q, kill_d;
  logic [DATA_W-1:0] hold_buf_q, hold_buf_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] incr_pc_q, incr_pc_d;

  logic [ADDR_W-1:0] target;
  logic              unused_target_lsb;

  assign target            = {branch_target[ADDR_W-1:2], 2'b00};
  assign unused_target_lsb = ^branch_target[1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= ADDR_W'(RESET_PC);
      fetch_addr_q <= ADDR_W'(RESET_PC);
      kill_q       <= 1'b0;
      hold_buf_q   <= '0;
      instr_q      <= NOP;
      incr_pc_q    <= ADDR_W'(RESET_PC);
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      kill_q       <= kill_d;
      hold_buf_q   <= hold_buf_d;
      instr_q      <= instr_d;
      incr_pc_q    <= incr_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    kill_d       = kill_q;
    hold_buf_d   = hold_buf_q;
    instr_d      = stall ? instr_q : NOP;
    incr_pc_d    = incr_pc_q;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_ready) begin
          fetch_addr_d = pc_q;
          pc_d         = pc_q + STEP;
          kill_d       = branch_taken;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          kill_d  = 1'b0;
          state_d = REQ;
          // A killed or just-redirected response is simply dropped here.
          if (!kill_q && !branch_taken) begin
            if (!stall) begin
              instr_d   = imem_rdata;
              incr_pc_d = fetch_addr_q + STEP;
            end else begin
              hold_buf_d = imem_rdata;
              state_d    = HOLD;
            end
          end
        end else if (branch_taken) begin
          kill_d = 1'b1;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          state_d = REQ;
        end else if (!stall) begin
          instr_d   = hold_buf_q;
          incr_pc_d = fetch_addr_q + STEP;
          state_d   = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    // Redirect wins over stall and over any delivery this cycle.
    if (branch_taken) begin
      pc_d    = target;
      instr_d = NOP;
    end
  end

  assign imem_req       = (state_q == REQ);
  assign imem_addr      = pc_q;
  assign instruction    = instr_q;
  assign incremented_pc = incr_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle-stepped memory model plus a second
// instance reset at the top of the address space to exercise PC wrap.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n, stall, branch_taken, imem_ready, imem_rvalid;
  logic [31:0] branch_target, imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr, instruction, incremented_pc;

  logic        w_rvalid, w_req;
  logic [31:0] w_rdata, w_addr, w_instr, w_incr;

  int n_checks = 0;
  int n_pass   = 0;

  // Memory model state
  int          lat = 1;
  int          cnt = 0;
  logic        pend = 1'b0;
  logic [31:0] paddr = '0;
  logic        special_en = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h00000000), .ADDR_W(32), .DATA_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instruction(instruction), .incremented_pc(incremented_pc)
  );

  fetch_unit #(.RESET_PC(32'hFFFFFFFC), .ADDR_W(32), .DATA_W(32)) u_wrap (
    .clk(clk), .rst_n(rst_n), .stall(1'b0), .branch_taken(1'b0),
    .branch_target(32'h0), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(1'b1), .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .instruction(w_instr), .incremented_pc(w_incr)
  );

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (special_en && a == 32'h8) return 32'h8C010004;
    return a << 4;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_out(input string tag, input logic [31:0] exp_instr,
                           input logic [31:0] exp_incr);
    check({tag, "_instr"}, instruction, exp_instr);
    check({tag, "_incr"}, incremented_pc, exp_incr);
  endtask

  // One clock: sample handshakes before the edge, then set memory responses
  // for the new cycle 1 time unit after it.
  task automatic cycle();
    logic        acc, rv, w_acc;
    logic [31:0] acc_addr, w_a;
    acc      = imem_req & imem_ready;
    acc_addr = imem_addr;
    rv       = imem_rvalid;
    w_acc    = w_req;
    w_a      = w_addr;
    @(posedge clk);
    #1;
    if (rv) pend = 1'b0;
    if (acc === 1'b1) begin
      pend  = 1'b1;
      cnt   = lat;
      paddr = acc_addr;
    end
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_data(paddr);
      end
    end
    w_rvalid = (w_acc === 1'b1);
    w_rdata  = w_rvalid ? (w_a << 4) : 32'h0;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    w_rvalid = 1'b0; w_rdata = '0;

    // Reset state
    cycle(); cycle();
    check_out("rst", 32'h0, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("wrap_rst_incr", w_incr, 32'hFFFFFFFC);
    check("wrap_rst_req", {31'b0, w_req}, 32'h0);
    rst_n = 1'b1;

    // Free run, 1-cycle memory
    cycle();
    check("run_req", {31'b0, imem_req}, 32'h1);
    check("run_addr0", imem_addr, 32'h0);
    check("wrap_addr0", w_addr, 32'hFFFFFFFC);
    cycle();
    cycle();
    check_out("run_d0", 32'h0, 32'h4);
    check("run_addr4", imem_addr, 32'h4);
    check("wrap_instr", w_instr, 32'hFFFFFFC0);
    check("wrap_incr", w_incr, 32'h0);
    check("wrap_next_addr", w_addr, 32'h0);
    cycle();
    check_out("run_nop1", 32'h0, 32'h4);
    cycle();
    check_out("run_d1", 32'h40, 32'h8);
    cycle();
    check_out("run_nop2", 32'h0, 32'h8);
    cycle();
    check_out("run_d2", 32'h80, 32'hC);

    // Stall across the response for address 0x8
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    special_en = 1'b1;
    repeat (5) cycle();
    check_out("stl_pre", 32'h40, 32'h8);
    check("stl_addr", imem_addr, 32'h8);
    stall = 1'b1;
    cycle();
    check_out("stl_h1", 32'h40, 32'h8);
    cycle();
    check_out("stl_h2", 32'h40, 32'h8);
    cycle();
    check_out("stl_h3", 32'h40, 32'h8);
    stall = 1'b0;
    cycle();
    check_out("stl_rel", 32'h8C010004, 32'hC);
    check("stl_next_addr", imem_addr, 32'hC);
    cycle();
    check_out("stl_nop", 32'h0, 32'hC);
    cycle();
    check_out("stl_d", 32'hC0, 32'h10);

    // Branch while waiting on 0x10 (3-cycle latency), flush beats stall
    stall = 1'b1;
    lat = 3;
    cycle();
    check_out("br_hold", 32'hC0, 32'h10);
    branch_taken = 1'b1; branch_target = 32'h100;
    cycle();
    check_out("br_flush", 32'h0, 32'h10);
    branch_taken = 1'b0; stall = 1'b0;
    cycle();
    lat = 1;
    cycle();
    check_out("br_drop", 32'h0, 32'h10);
    check("br_req", {31'b0, imem_req}, 32'h1);
    check("br_addr", imem_addr, 32'h100);
    cycle(); cycle();
    check_out("br_d", 32'h1000, 32'h104);

    // Branch coincident with rvalid, unaligned target
    cycle();
    branch_taken = 1'b1; branch_target = 32'h203;
    cycle();
    branch_taken = 1'b0;
    check_out("brv_drop", 32'h0, 32'h104);
    check("brv_addr", imem_addr, 32'h200);
    cycle(); cycle();
    check_out("brv_d", 32'h2000, 32'h204);

    // Branch in REQ without ready
    imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h300;
    cycle();
    branch_taken = 1'b0; imem_ready = 1'b1;
    check("brq_req", {31'b0, imem_req}, 32'h1);
    check("brq_addr", imem_addr, 32'h300);
    cycle(); cycle();
    check_out("brq_d", 32'h3000, 32'h304);

    // Reset mid-WAIT; late response lands while IDLE
    lat = 2;
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    lat = 1;
    check_out("mrst", 32'h0, 32'h0);
    check("mrst_req", {31'b0, imem_req}, 32'h0);
    cycle();
    check_out("mrst_idle", 32'h0, 32'h0);
    check("mrst_addr", imem_addr, 32'h0);
    check("mrst_req2", {31'b0, imem_req}, 32'h1);
    cycle(); cycle();
    check_out("mrst_d", 32'h0, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
